// File: rtl/set_pkg.sv
// Shared types and constants for the circle-set scan controller and its point evaluator.
package set_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_A   = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_TWO = 2'b11;

  localparam int GRID_N  = 8;
  localparam int COORD_W = 4;
  localparam int DIST_W  = 9;

endpackage

// File: rtl/set_point_eval.sv
// Combinational membership test of one grid point against three circles, combined
// according to the selected set operation.
module set_point_eval
  import set_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [23:0]        central,
  input  logic [11:0]        radius,
  input  logic [1:0]         mode,
  output logic               hit
);

  // |d| fits in 4 bits (max 14), so squares fit 8 bits and the sum 9 bits.
  function automatic logic in_circle(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                     input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy,
                                     input logic [COORD_W-1:0] r);
    logic signed [4:0]   dx;
    logic signed [4:0]   dy;
    logic [4:0]          adx;
    logic [4:0]          ady;
    logic [7:0]          sx;
    logic [7:0]          sy;
    logic [DIST_W-1:0]   d2;
    logic [DIST_W-1:0]   r2;
    dx  = signed'({1'b0, px}) - signed'({1'b0, cx});
    dy  = signed'({1'b0, py}) - signed'({1'b0, cy});
    adx = dx[4] ? 5'(-dx) : 5'(dx);
    ady = dy[4] ? 5'(-dy) : 5'(dy);
    sx  = 8'(adx) * 8'(adx);
    sy  = 8'(ady) * 8'(ady);
    d2  = {1'b0, sx} + {1'b0, sy};
    r2  = {1'b0, 8'(r) * 8'(r)};
    return d2 <= r2;
  endfunction

  logic in_a;
  logic in_b;
  logic in_c;

  always_comb begin
    in_a = in_circle(x, y, central[23:20], central[19:16], radius[11:8]);
    in_b = in_circle(x, y, central[15:12], central[11:8],  radius[7:4]);
    in_c = in_circle(x, y, central[7:4],   central[3:0],   radius[3:0]);
    case (mode)
      MODE_A:   hit = in_a;
      MODE_AND: hit = in_a & in_b;
      MODE_XOR: hit = in_a ^ in_b;
      default:  hit = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) | (~in_a & in_b & in_c);
    endcase
  end

endmodule

// File: rtl/set_scan_ctrl.sv
// Scan controller: latches one query, sweeps the 64 grid points through a single
// evaluator and reports the hit count with a one-cycle valid pulse.
module set_scan_ctrl
  import set_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [23:0]        central,
  input  logic [11:0]        radius,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               valid,
  output logic [COUNT_W-1:0] candidate,
  output state_t             state_dbg
);

  // Handshake: a query is taken on any edge where en=1 and the FSM is IDLE;
  // valid is a single-cycle pulse and candidate holds until the next pulse.

  state_t       st;
  logic [5:0]   k;
  logic [6:0]   cnt;
  logic [23:0]  sh_central;
  logic [11:0]  sh_radius;
  logic [1:0]   sh_mode;
  logic         hit;
  logic [6:0]   cnt_next;
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;

  // x-major scan: k[5:3] selects the column, k[2:0] the row, both 1-based.
  assign px       = {1'b0, k[5:3]} + 4'd1;
  assign py       = {1'b0, k[2:0]} + 4'd1;
  assign cnt_next = cnt + {6'd0, hit};
  assign state_dbg = st;

  set_point_eval u_eval (
    .x       (px),
    .y       (py),
    .central (sh_central),
    .radius  (sh_radius),
    .mode    (sh_mode),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      k          <= '0;
      cnt        <= '0;
      sh_central <= '0;
      sh_radius  <= '0;
      sh_mode    <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      candidate  <= '0;
    end else begin
      valid <= 1'b0;
      case (st)
        IDLE: begin
          if (en) begin
            sh_central <= central;
            sh_radius  <= radius;
            sh_mode    <= mode;
            cnt        <= '0;
            k          <= '0;
            busy       <= 1'b1;
            st         <= SCAN;
          end
        end
        SCAN: begin
          cnt <= cnt_next;
          k   <= k + 6'd1;
          if (k == 6'd63) begin
            candidate <= COUNT_W'(cnt_next);
            valid     <= 1'b1;
            st        <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Bench for set_scan_ctrl: reference count model plus cycle-by-cycle output checks.
module tb_set_scan_ctrl;
  import set_pkg::*;

  localparam int COUNT_W = 8;

  logic               clk;
  logic               rst;
  logic               en;
  logic [23:0]        central;
  logic [11:0]        radius;
  logic [1:0]         mode;
  logic               busy;
  logic               valid;
  logic [COUNT_W-1:0] candidate;
  state_t             state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_on   = 0;

  // model state
  int m_age    = -1;
  int m_res    = 0;
  int m_cand   = 0;

  logic [COUNT_W-1:0] exp_q[$];

  set_scan_ctrl #(.COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .central   (central),
    .radius    (radius),
    .mode      (mode),
    .busy      (busy),
    .valid     (valid),
    .candidate (candidate),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference ----------------
  function automatic int ref_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int cnt;
    int cx[3];
    int cy[3];
    int rr[3];
    bit in[3];
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cx[i] = int'(c[23 - 8*i -: 4]);
      cy[i] = int'(c[19 - 8*i -: 4]);
      rr[i] = int'(r[11 - 4*i -: 4]);
    end
    for (int x = 1; x <= 8; x++)
      for (int y = 1; y <= 8; y++) begin
        for (int i = 0; i < 3; i++)
          in[i] = ((x - cx[i]) * (x - cx[i]) + (y - cy[i]) * (y - cy[i])) <= rr[i] * rr[i];
        case (m)
          2'd0: cnt += int'(in[0]);
          2'd1: cnt += int'(in[0] && in[1]);
          2'd2: cnt += int'(in[0] != in[1]);
          default: cnt += int'((int'(in[0]) + int'(in[1]) + int'(in[2])) == 2);
        endcase
      end
    return cnt;
  endfunction

  function automatic logic [23:0] pack_c(input int x1, input int y1, input int x2, input int y2,
                                         input int x3, input int y3);
    return {4'(x1), 4'(y1), 4'(x2), 4'(y2), 4'(x3), 4'(y3)};
  endfunction

  // Timeline model: m_age counts edges since the accepting edge; result shows 64 edges later.
  always @(posedge clk) begin
    if (rst) begin
      m_age  = -1;
      m_cand = 0;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age == 64) m_cand = m_res;
      if (m_age == 65) m_age = -1;
    end else if (en) begin
      m_age = 0;
      m_res = ref_count(central, radius, mode);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", int'(busy), int'(m_age >= 0));
      chk("valid", int'(valid), int'(m_age == 64));
      chk("candidate", int'(candidate), m_cand);
      if (valid) exp_q.push_back(COUNT_W'(m_cand));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1; en = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_query(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input int exp_lit, input string name);
    bit ok;
    int t0;
    @(negedge clk);
    central = c; radius = r; mode = m; en = 1;
    t0 = cyc;
    @(negedge clk);
    en = 0;
    wait_valid(ok);
    chk({name, "_timeout"}, int'(ok), 1);
    chk({name, "_latency"}, cyc - t0, 65);
    if (exp_lit >= 0) chk({name, "_lit"}, int'(candidate), exp_lit);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int pulses;
    int tp[3];
    logic [23:0] c4;
    rst = 1; en = 0; central = '0; radius = '0; mode = '0;
    do_reset();
    @(negedge clk);
    chk_on = 1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_cand", int'(candidate), 0);
    chk("rst_state", int'(state_dbg), int'(IDLE));

    // model pins
    c4 = pack_c(4, 4, 4, 4, 4, 4);
    chk("pin_r2", ref_count(c4, 12'h222, 2'd0), 13);
    chk("pin_r15", ref_count(c4, 12'hF00, 2'd0), 64);
    chk("pin_origin", ref_count(pack_c(0, 0, 0, 0, 0, 0), 12'h100, 2'd0), 0);

    // directed queries
    run_query(c4, 12'h222, 2'd0, 13, "a_r2");
    run_query(c4, 12'hF00, 2'd0, 64, "a_r15");
    run_query(c4, 12'h000, 2'd0, 1, "a_r0");
    run_query(pack_c(0, 0, 0, 0, 0, 0), 12'h100, 2'd0, 0, "a_origin");
    run_query(c4, 12'h222, 2'd1, 13, "and");
    run_query(c4, 12'h222, 2'd2, 0, "xor");
    run_query(c4, 12'h222, 2'd3, 0, "two");
    run_query(pack_c(4, 4, 4, 4, 8, 8), 12'h220, 2'd3, 13, "two_c88");

    // input churn during scan
    @(negedge clk);
    central = c4; radius = 12'h222; mode = 2'd0; en = 1;
    @(negedge clk);
    for (int i = 0; i < 62; i++) begin
      en = 1'($urandom_range(0, 1));
      central = 24'($urandom);
      radius = 12'($urandom);
      mode = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    en = 0;
    wait_valid(ok);
    chk("churn_timeout", int'(ok), 1);
    chk("churn_lit", int'(candidate), 13);
    for (int i = 0; i < 5; i++) @(negedge clk);

    // reset mid-scan
    @(negedge clk);
    central = c4; radius = 12'h222; mode = 2'd0; en = 1;
    @(negedge clk);
    en = 0;
    for (int i = 0; i < 28; i++) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_cand", int'(candidate), 0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      if (valid) pulses++;
      @(negedge clk);
    end
    chk("midrst_no_pulse", pulses, 0);
    run_query(c4, 12'h222, 2'd0, 13, "after_rst");

    // back-to-back with en held high
    @(negedge clk);
    central = pack_c(3, 5, 6, 2, 1, 8); radius = 12'h435; mode = 2'd3; en = 1;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      wait_valid(ok);
      chk("b2b_timeout", int'(ok), 1);
      tp[p] = cyc;
      central = 24'($urandom); radius = 12'($urandom); mode = 2'($urandom_range(0, 3));
    end
    en = 0;
    chk("b2b_gap1", tp[1] - tp[0], 66);
    chk("b2b_gap2", tp[2] - tp[1], 66);
    for (int i = 0; i < 70; i++) @(negedge clk);

    // random queries
    for (int i = 0; i < 20; i++) begin
      int m;
      logic [23:0] c;
      logic [11:0] r;
      m = $urandom_range(0, 3);
      c = 24'($urandom);
      r = 12'($urandom);
      run_query(c, r, 2'(m), -1, "rand");
    end

    chk("pulse_queue_nonempty", int'(exp_q.size() > 0), 1);
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
